// File: rtl/l2_flush_walker_if.sv
// Flush-walker bus bundle: start/status, line-state read channel and evict
// channel. The walker uses the master side; the L2 control/tag/request-buffer
// side uses the slave side.
interface l2_flush_walker_if #(
    parameter int SET_BITS = 8,
    parameter int WAY_BITS = 3
);
    logic                         flush_start;
    logic                         flush_inv;
    logic                         ongoing_flush;
    logic                         tag_rd_valid;
    logic                         tag_rd_ready;
    logic [SET_BITS-1:0]          tag_rd_set;
    logic [WAY_BITS-1:0]          tag_rd_way;
    logic                         state_valid;
    logic [1:0]                   state_in;
    logic                         reqs_free;
    logic                         evict_valid;
    logic                         evict_ready;
    logic [SET_BITS-1:0]          evict_set;
    logic [WAY_BITS-1:0]          evict_way;
    logic                         evict_wb;
    logic                         fill_reqs_flush;
    logic                         flush_done;
    logic [SET_BITS+WAY_BITS:0]   evict_count;

    modport master (
        input  flush_start, flush_inv, tag_rd_ready, state_valid, state_in,
               reqs_free, evict_ready,
        output ongoing_flush, tag_rd_valid, tag_rd_set, tag_rd_way,
               evict_valid, evict_set, evict_way, evict_wb,
               fill_reqs_flush, flush_done, evict_count
    );

    modport slave (
        output flush_start, flush_inv, tag_rd_ready, state_valid, state_in,
               reqs_free, evict_ready,
        input  ongoing_flush, tag_rd_valid, tag_rd_set, tag_rd_way,
               evict_valid, evict_set, evict_way, evict_wb,
               fill_reqs_flush, flush_done, evict_count
    );
endinterface

// File: rtl/l2_flush_walker.sv
// L2 flush walker: visits every (set, way) with way as the inner loop, reads
// the line state and issues an evict (with writeback flag) for lines that must
// leave the cache. One shared set/way counter pair feeds both the read and the
// evict address.
module l2_flush_walker #(
    parameter int L2_SETS  = 256,
    parameter int L2_WAYS  = 8,
    parameter int SET_BITS = $clog2(L2_SETS),
    parameter int WAY_BITS = $clog2(L2_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,
    l2_flush_walker_if.master    bus
);
    localparam int CNT_BITS = SET_BITS + WAY_BITS + 1;
    localparam logic [SET_BITS-1:0] SET_LAST = SET_BITS'(L2_SETS - 1);
    localparam logic [WAY_BITS-1:0] WAY_LAST = WAY_BITS'(L2_WAYS - 1);
    localparam logic [1:0] ST_INVALID  = 2'd0;
    localparam logic [1:0] ST_MODIFIED = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_EVICT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [SET_BITS-1:0]   set_q, set_d;
    logic [WAY_BITS-1:0]   way_q, way_d;
    logic                  inv_q, inv_d;
    logic                  wb_q, wb_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  evict_hs;
    logic                  evict_now;

    // State and walk registers; reset abandons any in-flight read or evict.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            set_q   <= '0;
            way_q   <= '0;
            inv_q   <= 1'b0;
            wb_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
            inv_q   <= inv_d;
            wb_q    <= wb_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter updates for the set/way walk.
    always_comb begin
        state_d   = state_q;
        set_d     = set_q;
        way_d     = way_q;
        inv_d     = inv_q;
        wb_d      = wb_q;
        cnt_d     = cnt_q;
        evict_hs  = (state_q == S_EVICT) && bus.reqs_free && bus.evict_ready;
        evict_now = inv_q ? (bus.state_in != ST_INVALID)
                          : (bus.state_in == ST_MODIFIED);
        case (state_q)
            S_IDLE: begin
                if (bus.flush_start) begin
                    inv_d   = bus.flush_inv;
                    set_d   = '0;
                    way_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (bus.tag_rd_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.state_valid) begin
                    if (evict_now) begin
                        wb_d    = (bus.state_in == ST_MODIFIED);
                        state_d = S_EVICT;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_EVICT: begin
                if (evict_hs) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                way_d = way_q + WAY_BITS'(1);
                if (way_q == WAY_LAST) begin
                    way_d = '0;
                    set_d = set_q + SET_BITS'(1);
                end
                if ((set_q == SET_LAST) && (way_q == WAY_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ongoing_flush   = (state_q != S_IDLE);
    assign bus.tag_rd_valid    = (state_q == S_RD);
    assign bus.tag_rd_set      = set_q;
    assign bus.tag_rd_way      = way_q;
    assign bus.evict_valid     = (state_q == S_EVICT) && bus.reqs_free;
    assign bus.evict_set       = set_q;
    assign bus.evict_way       = way_q;
    assign bus.evict_wb        = wb_q;
    assign bus.fill_reqs_flush = evict_hs && wb_q;
    assign bus.flush_done      = (state_q == S_DONE);
    assign bus.evict_count     = cnt_q;
endmodule

// File: tb/tb_l2_flush_walker.sv
// Bench for l2_flush_walker on a 4-set, 2-way cache. A line-state memory and
// a reference walk model produce expected reads, evicts and done counts that
// a negedge monitor checks as the DUT presents handshakes.
module tb_l2_flush_walker;
    localparam int SETS = 4;
    localparam int WAYS = 2;
    localparam int SB   = 2;
    localparam int WB   = 1;
    localparam int N    = SETS * WAYS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_flush_walker_if #(.SET_BITS(SB), .WAY_BITS(WB)) bus ();

    l2_flush_walker #(
        .L2_SETS (SETS),
        .L2_WAYS (WAYS),
        .SET_BITS(SB),
        .WAY_BITS(WB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [1:0] mem [SETS][WAYS];
    int exp_rd[$];
    int exp_ev[$];
    int exp_done[$];
    bit rnd = 0;
    bit manual_ev = 0;
    bit rsp_pending = 0;
    bit rsp_hold = 0;
    logic [1:0] rsp_state = 2'd0;
    int hold_at = -1;
    int rd_hs_cnt = 0;
    bit done_seen = 0;
    int done_cyc = 0;
    int t0 = 0;
    int mon_e;
    int nev;
    int lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference walk: every line in set-major, way-minor order; evict rule
    // from the flush mode; done reports the number of evicts.
    task automatic build_expect(input bit inv, output int n_ev);
        n_ev = 0;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                exp_rd.push_back(s * WAYS + w);
                if ((inv && mem[s][w] != 2'd0) || (!inv && mem[s][w] == 2'd3)) begin
                    exp_ev.push_back(((mem[s][w] == 2'd3) ? 256 : 0) + s * WAYS + w);
                    n_ev++;
                end
            end
        end
        exp_done.push_back(n_ev);
    endtask

    task automatic start_flush(input bit inv, output int n_ev);
        build_expect(inv, n_ev);
        rd_hs_cnt = 0;
        done_seen = 0;
        @(posedge clk); #1;
        bus.flush_inv   = inv;
        bus.flush_start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        bus.flush_start = 1'b0;
        bus.flush_inv   = 1'($urandom);
        check("ongoing_at_T1", int'(bus.ongoing_flush), 1);
        check("rd_valid_at_T1", int'(bus.tag_rd_valid), 1);
    endtask

    task automatic wait_done(output int latency);
        for (int i = 0; i < 3000 && !done_seen; i++) @(posedge clk);
        if (!done_seen) flag("done_timeout");
        latency = done_cyc - t0;
        @(posedge clk); #1;
    endtask

    task automatic wait_reads(input int n);
        for (int i = 0; i < 500 && rd_hs_cnt < n; i++) @(negedge clk);
        if (rd_hs_cnt < n) flag("read_wait_timeout");
    endtask

    task automatic clear_mem();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                mem[s][w] = 2'd0;
    endtask

    task automatic random_mem();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                mem[s][w] = 2'($urandom);
    endtask

    // Environment: read acceptance, line-state responses and request buffer.
    initial forever begin
        @(posedge clk); #1;
        if (bus.state_valid) begin
            bus.state_valid = 1'b0;
        end else if (rsp_pending && !rsp_hold && (!rnd || $urandom_range(0, 2) == 0)) begin
            bus.state_valid = 1'b1;
            bus.state_in    = rsp_state;
            rsp_pending     = 1'b0;
        end
        if (!bus.state_valid) bus.state_in = 2'($urandom);
        bus.tag_rd_ready = rnd ? 1'($urandom) : 1'b1;
        if (!manual_ev) begin
            bus.reqs_free   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.evict_ready = rnd ? 1'($urandom) : 1'b1;
        end
    end

    // Monitor: scoreboard pops on read/evict handshakes and on flush_done.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.tag_rd_valid && bus.tag_rd_ready) begin
                rd_hs_cnt++;
                if (exp_rd.size() == 0) begin
                    flag("unexpected_read");
                end else begin
                    mon_e = exp_rd.pop_front();
                    check("rd_set", int'(bus.tag_rd_set), mon_e / WAYS);
                    check("rd_way", int'(bus.tag_rd_way), mon_e % WAYS);
                end
                rsp_state   = mem[bus.tag_rd_set][bus.tag_rd_way];
                rsp_pending = 1'b1;
                if (rd_hs_cnt == hold_at) rsp_hold = 1'b1;
            end
            if (bus.evict_valid) check("evict_needs_free", int'(bus.reqs_free), 1);
            if (bus.evict_valid && bus.evict_ready) begin
                if (exp_ev.size() == 0) begin
                    flag("unexpected_evict");
                end else begin
                    mon_e = exp_ev.pop_front();
                    check("ev_set", int'(bus.evict_set), (mon_e % 256) / WAYS);
                    check("ev_way", int'(bus.evict_way), (mon_e % 256) % WAYS);
                    check("ev_wb", int'(bus.evict_wb), mon_e / 256);
                    check("fill_on_hs", int'(bus.fill_reqs_flush), mon_e / 256);
                end
            end else begin
                check("fill_no_hs", int'(bus.fill_reqs_flush), 0);
            end
            if (bus.flush_done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                if (exp_done.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    check("done_evict_count", int'(bus.evict_count), exp_done.pop_front());
                    check("done_reads_left", exp_rd.size(), 0);
                    check("done_evicts_left", exp_ev.size(), 0);
                end
            end
        end
    end

    initial begin
        bus.flush_start  = 1'b0;
        bus.flush_inv    = 1'b0;
        bus.tag_rd_ready = 1'b0;
        bus.state_valid  = 1'b0;
        bus.state_in     = 2'd0;
        bus.reqs_free    = 1'b0;
        bus.evict_ready  = 1'b0;
        clear_mem();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ongoing", int'(bus.ongoing_flush), 0);
        check("rst_rd_valid", int'(bus.tag_rd_valid), 0);
        check("rst_evict_valid", int'(bus.evict_valid), 0);
        check("rst_evict_count", int'(bus.evict_count), 0);
        check("rst_done", int'(bus.flush_done), 0);
        check("rst_evict_wb", int'(bus.evict_wb), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // All lines INVALID, writeback mode: 8 reads, no evicts.
        start_flush(1'b0, nev);
        wait_done(lat);
        check("lat_all_invalid", lat, 3 * N + 1);

        // s1w1 MODIFIED, s2w0 SHARED, writeback mode.
        mem[1][1] = 2'd3;
        mem[2][0] = 2'd1;
        start_flush(1'b0, nev);
        wait_done(lat);
        check("lat_wb_mixed", lat, 3 * N + 1 + 1);
        check("count_wb_mixed", int'(bus.evict_count), 1);

        // Same states, invalidate mode.
        start_flush(1'b1, nev);
        wait_done(lat);
        check("lat_inv_mixed", lat, 3 * N + 2 + 1);
        check("count_inv_mixed", int'(bus.evict_count), 2);

        // Backpressure on the evict of s0w1.
        clear_mem();
        mem[0][1] = 2'd3;
        manual_ev = 1'b1;
        bus.reqs_free   = 1'b0;
        bus.evict_ready = 1'b1;
        start_flush(1'b0, nev);
        wait_reads(2);
        repeat (12) begin
            @(negedge clk);
            check("bp_no_free_valid", int'(bus.evict_valid), 0);
            check("bp_set_stable", int'(bus.evict_set), 0);
            check("bp_way_stable", int'(bus.evict_way), 1);
        end
        @(posedge clk); #1;
        bus.reqs_free   = 1'b1;
        bus.evict_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_valid_held", int'(bus.evict_valid), 1);
            check("bp_set_held", int'(bus.evict_set), 0);
            check("bp_way_held", int'(bus.evict_way), 1);
        end
        @(posedge clk); #1;
        bus.evict_ready = 1'b1;
        @(posedge clk); #1;
        manual_ev = 1'b0;
        wait_done(lat);
        check("bp_count", int'(bus.evict_count), 1);

        // Start ignored mid-walk, then reset while waiting on a response.
        clear_mem();
        mem[0][0] = 2'd3;
        mem[0][1] = 2'd1;
        hold_at = 5;
        start_flush(1'b1, nev);
        wait_reads(2);
        @(posedge clk); #1;
        bus.flush_start = 1'b1;
        @(posedge clk); #1;
        bus.flush_start = 1'b0;
        wait_reads(5);
        repeat (3) @(negedge clk);
        check("pre_rst_ongoing", int'(bus.ongoing_flush), 1);
        check("pre_rst_count", int'(bus.evict_count), 2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd.delete();
        exp_ev.delete();
        exp_done.delete();
        rsp_pending = 1'b0;
        rsp_hold    = 1'b0;
        hold_at     = -1;
        done_seen   = 1'b0;
        @(negedge clk);
        check("mid_rst_ongoing", int'(bus.ongoing_flush), 0);
        check("mid_rst_rd_valid", int'(bus.tag_rd_valid), 0);
        check("mid_rst_evict_valid", int'(bus.evict_valid), 0);
        check("mid_rst_count", int'(bus.evict_count), 0);
        check("mid_rst_set", int'(bus.tag_rd_set), 0);
        check("mid_rst_way", int'(bus.tag_rd_way), 0);
        check("mid_rst_wb", int'(bus.evict_wb), 0);
        repeat (10) @(negedge clk);
        check("no_done_after_rst", int'(done_seen), 0);
        random_mem();
        start_flush(1'b1, nev);
        wait_done(lat);
        check("post_rst_lat", lat, 3 * N + nev + 1);

        // Randomized walks with random handshake timing.
        rnd = 1'b1;
        for (int k = 0; k < 8; k++) begin
            random_mem();
            start_flush(1'($urandom), nev);
            wait_done(lat);
            check("rnd_count", int'(bus.evict_count), nev);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
